mac_accumulator: RTL and testbench

- Downstream stage of the fixed-point multiplier. Accepts a stream of signed, already-scaled products and sums a programmable number of them (one kernel window).
- Emits one saturated signed result per window over a valid/ready handshake.
- Sits between the multiplier array and the output/requantisation buffer of the PE datapath.

---
 rtl/mac_accumulator_if.sv | 24 ++
 rtl/mac_accumulator.sv | 82 ++++++++
 tb/tb_mac_accumulator.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mac_accumulator_if.sv
// mac_accumulator_if: product stream in, saturated window result out, plus window control.
interface mac_accumulator_if #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 16,
    parameter int CNT_WIDTH = 8
);
    logic [CNT_WIDTH-1:0] num_terms;
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 overflow;
    modport master (
        output num_terms, flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, overflow
    );
    modport slave (
        input  num_terms, flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, overflow
    );
endinterface

// File: rtl/mac_accumulator.sv
// mac_accumulator: sums num_terms signed products per window, emits a saturated result; ACCUM_RELU_EN clamps negative results to 0.
module mac_accumulator #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 16,
    parameter int CNT_WIDTH = 8,
    parameter int ACC_WIDTH = IN_WIDTH + CNT_WIDTH
) (
    input logic              clk,
    input logic              arst_n_in,
    mac_accumulator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
    localparam logic signed [ACC_WIDTH-1:0] MAX_P = {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] MIN_N = ~MAX_P;
    state_t                       state, state_nxt;
    logic signed [ACC_WIDTH-1:0]  acc, acc_nxt, ext, sum;
    logic [CNT_WIDTH-1:0]         cnt, cnt_nxt, cnt_inc, n, n_nxt, n_eff;
    logic [OUT_WIDTH-1:0]         out_data, od_nxt, sat, res;
    logic                         overflow, ov_nxt, clip, res_ov, done;
    // acc and cnt are zero in IDLE, so the same adder serves the first term
    assign ext     = {{(ACC_WIDTH-IN_WIDTH){bus.in_data[IN_WIDTH-1]}}, bus.in_data};
    assign sum     = acc + ext;
    assign cnt_inc = cnt + CNT_WIDTH'(1);
    assign n_eff   = (state == IDLE) ? ((bus.num_terms == '0) ? CNT_WIDTH'(1) : bus.num_terms) : n;
    assign done    = cnt_inc == n_eff;
    assign clip    = (sum > MAX_P) || (sum < MIN_N);
    assign sat     = (sum > MAX_P) ? MAX_P[OUT_WIDTH-1:0] : (sum < MIN_N) ? MIN_N[OUT_WIDTH-1:0] : sum[OUT_WIDTH-1:0];
`ifdef ACCUM_RELU_EN
    assign res    = sat[OUT_WIDTH-1] ? '0 : sat;
    assign res_ov = clip && !sat[OUT_WIDTH-1];
`else
    assign res    = sat;
    assign res_ov = clip;
`endif
    assign bus.in_ready  = state != HOLD;
    assign bus.out_valid = state == HOLD;
    assign bus.out_data  = out_data;
    assign bus.overflow  = overflow;
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        n_nxt     = n;
        od_nxt    = out_data;
        ov_nxt    = overflow;
        if (state == HOLD) begin
            if (bus.out_ready) begin
                state_nxt = IDLE;
                acc_nxt   = '0;
                cnt_nxt   = '0;
            end
        end else if (bus.flush) begin
            state_nxt = IDLE;
            acc_nxt   = '0;
            cnt_nxt   = '0;
        end else if (bus.in_valid) begin
            acc_nxt   = sum;
            cnt_nxt   = cnt_inc;
            n_nxt     = n_eff;
            state_nxt = done ? HOLD : ACCUM;
            od_nxt    = done ? res : out_data;
            ov_nxt    = done ? res_ov : overflow;
        end
    end
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            n        <= '0;
            out_data <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            acc      <= acc_nxt;
            cnt      <= cnt_nxt;
            n        <= n_nxt;
            out_data <= od_nxt;
            overflow <= ov_nxt;
        end
    end
endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: directed plus random windows against a queue-based reference model with a decoupled output monitor.
module tb_mac_accumulator;
    localparam int IW = 16, OW = 16, CW = 8;
    localparam int MAXV = (1 << (OW - 1)) - 1;
    localparam int MINV = -(1 << (OW - 1));
    typedef struct {int d; int ov;} res_t;
    logic clk = 1'b0;
    logic arst_n_in = 1'b0;
    always #5 clk = ~clk;
    mac_accumulator_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .CNT_WIDTH(CW)) bus ();
    mac_accumulator #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .arst_n_in(arst_n_in), .bus(bus.slave)
    );
    res_t exp_q[$];
    int   win[$];
    int   win_n, checks, errors, cyc, lat_cycle, out_mode, nt;
    bit   hold_prev, hs_prev, a;
    int   hold_d, hold_ov;

    function automatic void chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // reference: plain integer sum of the window, then clip (and optional relu)
    function automatic void model_accept(int d);
        int s;
        res_t r;
        if (win.size() == 0) win_n = (bus.num_terms == 0) ? 1 : int'(bus.num_terms);
        win.push_back(d);
        if (win.size() == win_n) begin
            s = 0;
            foreach (win[i]) s += win[i];
            r.d  = s > MAXV ? MAXV : s < MINV ? MINV : s;
            r.ov = (s > MAXV || s < MINV) ? 1 : 0;
`ifdef ACCUM_RELU_EN
            if (r.d < 0) begin
                r.d  = 0;
                r.ov = 0;
            end
`endif
            exp_q.push_back(r);
            win.delete();
            lat_cycle = cyc + 1;
        end
    endfunction

    always @(posedge clk or negedge arst_n_in) cyc <= arst_n_in ? cyc + 1 : cyc;

    always @(negedge clk) begin
        if (!arst_n_in) begin
            hold_prev = 0;
            hs_prev   = 0;
        end else begin
            if (cyc == lat_cycle) chk("latency_out_valid", int'(bus.out_valid), 1);
            if (hs_prev) chk("in_ready_after_handshake", int'(bus.in_ready), 1);
            if (hold_prev) begin
                chk("hold_valid", int'(bus.out_valid), 1);
                chk("hold_data", int'($signed(bus.out_data)), hold_d);
                chk("hold_overflow", int'(bus.overflow), hold_ov);
            end
            if (bus.out_valid) begin
                chk("in_ready_low_while_pending", int'(bus.in_ready), 0);
                if (bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got %0d, expected no result", $signed(bus.out_data));
                    end else begin
                        res_t e;
                        e = exp_q.pop_front();
                        chk("out_data", int'($signed(bus.out_data)), e.d);
                        chk("overflow", int'(bus.overflow), e.ov);
                    end
                end
            end
            hs_prev   = bus.out_valid && bus.out_ready;
            hold_prev = bus.out_valid && !bus.out_ready;
            hold_d    = int'($signed(bus.out_data));
            hold_ov   = int'(bus.overflow);
        end
    end

    task automatic cycle(input bit v, input int d, input bit f, output bit acc);
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.in_data   = IW'(d);
        bus.flush     = f;
        bus.num_terms = CW'(nt);
        bus.out_ready = out_mode == 0 ? 1'b1 : out_mode == 1 ? 1'b0 : 1'($urandom_range(0, 1));
        @(negedge clk);
        acc = v && bus.in_ready && !f;
        if (acc) model_accept(d);
        if (f && bus.in_ready) win.delete();
    endtask

    task automatic send(input int d);
        bit ok;
        for (int i = 0; i < 200; i++) begin
            cycle(1'b1, d, 1'b0, ok);
            if (ok) return;
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: got in_ready stuck low, expected accept of %0d", d);
    endtask

    task automatic idle(input int k);
        bit x;
        repeat (k) cycle(1'b0, 0, 1'b0, x);
    endtask

    task automatic drain();
        out_mode = 0;
        for (int i = 0; i < 300; i++) begin
            idle(1);
            if (exp_q.size() == 0 && !bus.out_valid) return;
        end
        checks++;
        errors++;
        $display("FAIL drain_timeout: got %0d results outstanding, expected 0", exp_q.size());
    endtask

    initial begin
        bus.in_valid = 0; bus.in_data = '0; bus.flush = 0; bus.num_terms = '0; bus.out_ready = 1;
        cyc = 0; lat_cycle = -1; out_mode = 0; nt = 4; checks = 0; errors = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", int'(bus.out_valid), 0);
        chk("reset_out_data", int'(bus.out_data), 0);
        chk("reset_overflow", int'(bus.overflow), 0);
        @(posedge clk);
        #3 arst_n_in = 1;
        @(negedge clk);
        chk("reset_in_ready", int'(bus.in_ready), 1);
        // basic 4-term window
        nt = 4;
        send(100); send(-30); send(7); send(1);
        drain();
        // positive and negative saturation
        nt = 3;
        send(20000); send(20000); send(-1000);
        drain();
        send(-20000); send(-20000); send(1000);
        drain();
        // back-pressure: result must stay stable and extra inputs refused
        nt = 2;
        send(5); send(6);
        out_mode = 1;
        repeat (5) begin
            cycle(1'b1, 77, 1'b0, a);
            chk("hold_no_accept", int'(a), 0);
        end
        drain();
        // flush drops the partial sum and the coincident input
        nt = 5;
        send(1); send(2);
        cycle(1'b1, 9, 1'b1, a);
        for (int i = 1; i <= 5; i++) send(i);
        drain();
        // num_terms==0 means one term; mid-window num_terms change ignored
        nt = 0;
        send(-5);
        drain();
        nt = 3;
        send(1);
        nt = 6;
        send(2); send(3);
        drain();
        // asynchronous reset mid-window
        nt = 4;
        send(1); send(1);
        idle(1);
        #2 arst_n_in = 0;
        #1;
        chk("async_reset_out_valid", int'(bus.out_valid), 0);
        chk("async_reset_out_data", int'(bus.out_data), 0);
        chk("async_reset_overflow", int'(bus.overflow), 0);
        win.delete();
        lat_cycle = -1;
        @(posedge clk);
        #3 arst_n_in = 1;
        for (int i = 0; i < 4; i++) send(1);
        drain();
        // random windows with random back-pressure, flushes and num_terms churn
        out_mode = 2;
        for (int i = 0; i < 600; i++) begin
            int d;
            nt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(20, 60)) : int'($urandom_range(0, 6));
            d  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 400)) - 200;
            cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 29) == 0, a);
        end
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
